// File: rtl/risk_ldst_seq_if.sv
// rtl/risk_ldst_seq_if.sv - command, memory and register-file signal bundle for risk_ldst_seq
interface risk_ldst_seq_if #(
  parameter int ROWW = 288
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [4:0]      cmd_reg;
  logic [1:0]      cmd_rows_m1;
  logic [14:0]     cmd_addr;
  logic [13:0]     cmd_stride_x;
  logic [13:0]     cmd_stride_y;
  logic [14:0]     mem_addr;
  logic [13:0]     mem_stride_x;
  logic [13:0]     mem_stride_y;
  logic            mem_we;
  logic [ROWW-1:0] mem_dat_w;
  logic [ROWW-1:0] mem_dat_r;
  logic [4:0]      rf_rreg;
  logic [1:0]      rf_rrow;
  logic [ROWW-1:0] rf_rdata;
  logic            rf_we;
  logic [4:0]      rf_wreg;
  logic [1:0]      rf_wrow;
  logic [ROWW-1:0] rf_wdata;
  logic            done_valid;
  logic [4:0]      done_reg;

  modport slave (
    input  cmd_valid, cmd_op, cmd_reg, cmd_rows_m1, cmd_addr, cmd_stride_x, cmd_stride_y,
    input  mem_dat_r, rf_rdata,
    output cmd_ready, mem_addr, mem_stride_x, mem_stride_y, mem_we, mem_dat_w,
    output rf_rreg, rf_rrow, rf_we, rf_wreg, rf_wrow, rf_wdata, done_valid, done_reg
  );

  modport master (
    output cmd_valid, cmd_op, cmd_reg, cmd_rows_m1, cmd_addr, cmd_stride_x, cmd_stride_y,
    output mem_dat_r, rf_rdata,
    input  cmd_ready, mem_addr, mem_stride_x, mem_stride_y, mem_we, mem_dat_w,
    input  rf_rreg, rf_rrow, rf_we, rf_wreg, rf_wrow, rf_wdata, done_valid, done_reg
  );
endinterface

// File: rtl/risk_ldst_seq.sv
// rtl/risk_ldst_seq.sv - tile load/store sequencer in front of risk_mem
module risk_ldst_seq #(
  parameter int BITS    = 18,
  parameter int SZ      = 4,
  parameter int MEM_LAT = 4,
  parameter int WE_DLY  = 2,
  parameter int DW_DLY  = 1
) (
  input  logic           clk,
  input  logic           rst,
  risk_ldst_seq_if.slave bus
);
  localparam int ROWW = BITS * SZ * SZ;
  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_ZERO  = 2'b10;

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, STORE, ZERO, FIN} state_t;

  state_t      state;
  logic        cmd_ready_q;
  logic        done_q;
  logic [1:0]  op_q;
  logic [1:0]  rows_m1_q;
  logic [4:0]  reg_q;
  logic [13:0] stride_y_q;
  logic [14:0] addr_q;
  logic [13:0] stride_x_q;

  logic        issue_ld;
  logic        issue_st;
  logic        issue_zero;
  logic        issue_last;
  logic [1:0]  issue_row;

  logic [MEM_LAT-1:0]        tag_v;
  logic [MEM_LAT-2:0]        tag_last;
  logic [MEM_LAT-1:0][1:0]   tag_row;
  logic [WE_DLY-1:0]         we_v;
  logic [WE_DLY-2:0]         we_last;
  logic [DW_DLY-1:0][ROWW-1:0] dw;

  logic ld_wr;
  logic drain_done;

  assign ld_wr = tag_v[MEM_LAT-1];
  // Completion is flagged one stage early so done_valid lands with the final write strobe.
  assign drain_done = (op_q == OP_LOAD) ? tag_last[MEM_LAT-2] : we_last[WE_DLY-2];

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_stride_x = stride_x_q;
  assign bus.mem_stride_y = '0;
  assign bus.mem_we       = we_v[WE_DLY-1] & ~rst;
  assign bus.mem_dat_w    = dw[DW_DLY-1];
  assign bus.rf_rreg      = reg_q;
  assign bus.rf_rrow      = issue_row;
  assign bus.rf_we        = (ld_wr | issue_zero) & ~rst;
  assign bus.rf_wreg      = reg_q;
  assign bus.rf_wrow      = ld_wr ? tag_row[MEM_LAT-1] : issue_row;
  assign bus.rf_wdata     = ld_wr ? bus.mem_dat_r : '0;
  assign bus.done_valid   = done_q & ~rst;
  assign bus.done_reg     = reg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
      op_q        <= '0;
      rows_m1_q   <= '0;
      reg_q       <= '0;
      stride_y_q  <= '0;
      addr_q      <= '0;
      stride_x_q  <= '0;
      issue_ld    <= 1'b0;
      issue_st    <= 1'b0;
      issue_zero  <= 1'b0;
      issue_last  <= 1'b0;
      issue_row   <= '0;
      tag_v       <= '0;
      tag_last    <= '0;
      tag_row     <= '0;
      we_v        <= '0;
      we_last     <= '0;
      dw          <= '0;
    end else begin
      tag_v[0]    <= issue_ld;
      tag_last[0] <= issue_ld & issue_last;
      tag_row[0]  <= issue_row;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_row[i] <= tag_row[i-1];
      end
      for (int i = 1; i < MEM_LAT - 1; i++) tag_last[i] <= tag_last[i-1];

      we_v[0]    <= issue_st;
      we_last[0] <= issue_st & issue_last;
      for (int i = 1; i < WE_DLY; i++) we_v[i] <= we_v[i-1];
      for (int i = 1; i < WE_DLY - 1; i++) we_last[i] <= we_last[i-1];

      dw[0] <= issue_st ? bus.rf_rdata : '0;
      for (int i = 1; i < DW_DLY; i++) dw[i] <= dw[i-1];

      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            cmd_ready_q <= 1'b0;
            op_q        <= bus.cmd_op;
            reg_q       <= bus.cmd_reg;
            rows_m1_q   <= bus.cmd_rows_m1;
            stride_y_q  <= bus.cmd_stride_y;
            issue_row   <= '0;
            issue_last  <= (bus.cmd_rows_m1 == 2'd0);
            case (bus.cmd_op)
              OP_LOAD: begin
                addr_q     <= bus.cmd_addr;
                stride_x_q <= bus.cmd_stride_x;
                issue_ld   <= 1'b1;
                state      <= LOAD;
              end
              OP_STORE: begin
                addr_q     <= bus.cmd_addr;
                stride_x_q <= bus.cmd_stride_x;
                issue_st   <= 1'b1;
                state      <= STORE;
              end
              OP_ZERO: begin
                issue_zero <= 1'b1;
                state      <= ZERO;
              end
              default: begin
                done_q <= 1'b1;
                state  <= FIN;
              end
            endcase
          end
        end
        LOAD, STORE: begin
          if (issue_last) begin
            issue_ld   <= 1'b0;
            issue_st   <= 1'b0;
            issue_last <= 1'b0;
            state      <= DRAIN;
          end else begin
            issue_row  <= issue_row + 2'd1;
            addr_q     <= addr_q + 15'(stride_y_q);
            issue_last <= ((issue_row + 2'd1) == rows_m1_q);
          end
        end
        ZERO: begin
          // Zeroing always clears the whole tile regardless of rows_m1.
          if (issue_row == 2'd2) begin
            issue_row <= 2'd3;
            done_q    <= 1'b1;
            state     <= FIN;
          end else begin
            issue_row <= issue_row + 2'd1;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            done_q <= 1'b1;
            state  <= FIN;
          end
        end
        FIN: begin
          done_q      <= 1'b0;
          issue_zero  <= 1'b0;
          issue_row   <= '0;
          cmd_ready_q <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_risk_ldst_seq.sv
// tb/tb_risk_ldst_seq.sv - scoreboard testbench for risk_ldst_seq
module tb_risk_ldst_seq;
  localparam int ROWW    = 288;
  localparam int MEM_LAT = 4;
  localparam int WE_DLY  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  risk_ldst_seq_if #(.ROWW(ROWW)) bus();
  risk_ldst_seq dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [14:0] addr; bit st; logic [4:0] rreg; logic [1:0] rrow; } iss_t;
  typedef struct { int cyc; logic [4:0] rg; logic [1:0] row; logic [ROWW-1:0] data; } rfw_t;
  typedef struct { int cyc; logic [ROWW-1:0] data; } dat_t;
  typedef struct { int cyc; logic [4:0] rg; } done_t;

  iss_t  iss_q[$];
  rfw_t  rfw_q[$];
  dat_t  datw_q[$];
  int    memw_q[$];
  done_t done_q[$];

  logic [14:0]     hist [MEM_LAT];
  logic [ROWW-1:0] rf_model [32][4];

  function automatic logic [ROWW-1:0] data_of(input logic [14:0] a);
    logic [ROWW-1:0] d;
    for (int i = 0; i < ROWW / 32; i++) d[i*32 +: 32] = ((32'(a) + 32'(i)) * 32'h9E3779B1) ^ 32'h13572468;
    return d;
  endfunction

  // Memory model: read data appears MEM_LAT cycles after the address.
  always @(posedge clk) begin
    hist[0] <= bus.mem_addr;
    for (int i = 1; i < MEM_LAT; i++) hist[i] <= hist[i-1];
  end
  assign bus.mem_dat_r = data_of(hist[MEM_LAT-1]);
  assign bus.rf_rdata  = rf_model[bus.rf_rreg][bus.rf_rrow];

  always @(negedge clk) begin
    iss_t ie; rfw_t re; dat_t de; done_t ne; int mc;
    if (mon_en) begin
      while (iss_q.size() > 0 && iss_q[0].cyc <= cyc) begin
        ie = iss_q.pop_front();
        checks++;
        if (ie.cyc != cyc || bus.mem_addr !== ie.addr ||
            (ie.st && (bus.rf_rreg !== ie.rreg || bus.rf_rrow !== ie.rrow))) begin
          errors++;
          $display("FAIL issue cyc %0d addr %h rreg %0d rrow %0d, want cyc %0d addr %h rreg %0d rrow %0d",
                   cyc, bus.mem_addr, bus.rf_rreg, bus.rf_rrow, ie.cyc, ie.addr, ie.rreg, ie.rrow);
        end
      end
      while (datw_q.size() > 0 && datw_q[0].cyc <= cyc) begin
        de = datw_q.pop_front();
        checks++;
        if (de.cyc != cyc || bus.mem_dat_w !== de.data) begin
          errors++;
          $display("FAIL mem_dat_w cyc %0d got %h, want cyc %0d %h", cyc, bus.mem_dat_w, de.cyc, de.data);
        end
      end
      while (rfw_q.size() > 0 && rfw_q[0].cyc < cyc) begin
        re = rfw_q.pop_front(); checks++; errors++;
        $display("FAIL rf_we missing: got none, want cyc %0d row %0d", re.cyc, re.row);
      end
      while (memw_q.size() > 0 && memw_q[0] < cyc) begin
        mc = memw_q.pop_front(); checks++; errors++;
        $display("FAIL mem_we missing: got none, want cyc %0d", mc);
      end
      while (done_q.size() > 0 && done_q[0].cyc < cyc) begin
        ne = done_q.pop_front(); checks++; errors++;
        $display("FAIL done missing: got none, want cyc %0d reg %0d", ne.cyc, ne.rg);
      end
      if (bus.rf_we) begin
        checks++;
        if (rfw_q.size() == 0) begin
          errors++;
          $display("FAIL rf_we unexpected at cyc %0d row %0d, want none", cyc, bus.rf_wrow);
        end else begin
          re = rfw_q.pop_front();
          if (re.cyc != cyc || bus.rf_wreg !== re.rg || bus.rf_wrow !== re.row || bus.rf_wdata !== re.data) begin
            errors++;
            $display("FAIL rf_we cyc %0d reg %0d row %0d data %h, want cyc %0d reg %0d row %0d data %h",
                     cyc, bus.rf_wreg, bus.rf_wrow, bus.rf_wdata, re.cyc, re.rg, re.row, re.data);
          end
        end
      end
      if (bus.mem_we) begin
        checks++;
        if (memw_q.size() == 0) begin
          errors++;
          $display("FAIL mem_we unexpected at cyc %0d, want none", cyc);
        end else begin
          mc = memw_q.pop_front();
          if (mc != cyc) begin
            errors++;
            $display("FAIL mem_we at cyc %0d, want cyc %0d", cyc, mc);
          end
        end
      end
      if (bus.done_valid) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL done unexpected at cyc %0d reg %0d, want none", cyc, bus.done_reg);
        end else begin
          ne = done_q.pop_front();
          if (ne.cyc != cyc || bus.done_reg !== ne.rg) begin
            errors++;
            $display("FAIL done cyc %0d reg %0d, want cyc %0d reg %0d", cyc, bus.done_reg, ne.cyc, ne.rg);
          end
        end
      end
      if (bus.rf_we || bus.mem_we) begin
        checks++;
        if (bus.rf_we && bus.mem_we) begin
          errors++;
          $display("FAIL we_overlap cyc %0d rf_we 1 mem_we 1, want not both", cyc);
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [4:0] rg, input logic [1:0] rm1,
                      input logic [14:0] addr, input logic [13:0] sx, input logic [13:0] sy,
                      input bit keep, output int acc);
    int rows;
    logic [14:0] a;
    @(negedge clk);
    bus.cmd_op = op; bus.cmd_reg = rg; bus.cmd_rows_m1 = rm1;
    bus.cmd_addr = addr; bus.cmd_stride_x = sx; bus.cmd_stride_y = sy;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 40 && !bus.cmd_ready; i++) @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept cmd_ready %b, want 1", bus.cmd_ready);
    end
    acc = cyc;
    rows = int'(rm1) + 1;
    a = addr;
    case (op)
      2'b00: begin
        for (int r = 0; r < rows; r++) begin
          iss_q.push_back('{acc + 1 + r, a, 1'b0, 5'd0, 2'd0});
          rfw_q.push_back('{acc + 1 + r + MEM_LAT, rg, 2'(r), data_of(a)});
          a = a + 15'(sy);
        end
        done_q.push_back('{acc + rows + MEM_LAT, rg});
      end
      2'b01: begin
        for (int r = 0; r < rows; r++) begin
          iss_q.push_back('{acc + 1 + r, a, 1'b1, rg, 2'(r)});
          datw_q.push_back('{acc + 2 + r, rf_model[rg][r]});
          memw_q.push_back(acc + 1 + r + WE_DLY);
          a = a + 15'(sy);
        end
        done_q.push_back('{acc + rows + WE_DLY, rg});
      end
      2'b10: begin
        for (int r = 0; r < 4; r++) rfw_q.push_back('{acc + 1 + r, rg, 2'(r), '0});
        done_q.push_back('{acc + 4, rg});
      end
      default: done_q.push_back('{acc + 1, rg});
    endcase
    @(posedge clk);
    #1;
    if (!keep) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (iss_q.size() == 0 && rfw_q.size() == 0 && datw_q.size() == 0 &&
          memw_q.size() == 0 && done_q.size() == 0 && bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.cmd_ready, bus.mem_we, bus.rf_we, bus.done_valid} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl ready/mem_we/rf_we/done %b, want 1000",
               {bus.cmd_ready, bus.mem_we, bus.rf_we, bus.done_valid});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_stride_x, bus.mem_stride_y} !== 43'd0) begin
      errors++;
      $display("FAIL reset_mem addr %h sx %h sy %h, want 0", bus.mem_addr, bus.mem_stride_x, bus.mem_stride_y);
    end
    checks++;
    if ({bus.rf_rreg, bus.rf_rrow, bus.rf_wreg, bus.rf_wrow, bus.done_reg} !== 19'd0 ||
        bus.mem_dat_w !== '0 || bus.rf_wdata !== '0) begin
      errors++;
      $display("FAIL reset_rf rreg %0d rrow %0d wreg %0d wrow %0d done_reg %0d, want 0",
               bus.rf_rreg, bus.rf_rrow, bus.rf_wreg, bus.rf_wrow, bus.done_reg);
    end
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_load_basic();
    int acc; bit ok;
    send(2'b00, 5'd5, 2'd3, 15'd100, 14'd1, 14'd8, 1'b0, acc);
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b0 || bus.mem_stride_x !== 14'd1 || bus.mem_stride_y !== 14'd0) begin
      errors++;
      $display("FAIL load_c1 ready %b sx %0d sy %0d, want 0 1 0", bus.cmd_ready, bus.mem_stride_x, bus.mem_stride_y);
    end
    while (cyc < acc + 8) @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_ready_c8 got %b, want 0", bus.cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_ready_c9 got %b, want 1", bus.cmd_ready);
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL load_basic drain got pending, want empty"); end
  endtask

  task automatic test_load_wrap();
    int acc; bit ok;
    send(2'b00, 5'd2, 2'd1, 15'h7FF8, 14'd3, 14'd8, 1'b0, acc);
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL load_wrap drain got pending, want empty"); end
  endtask

  task automatic test_store();
    int acc; bit ok;
    for (int r = 0; r < 4; r++)
      for (int w = 0; w < ROWW / 32; w++) rf_model[3][r][w*32 +: 32] = $urandom;
    send(2'b01, 5'd3, 2'd3, 15'd200, 14'd2, 14'd16, 1'b0, acc);
    @(negedge clk);
    checks++;
    if (bus.mem_stride_x !== 14'd2) begin
      errors++;
      $display("FAIL store_sx got %0d, want 2", bus.mem_stride_x);
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL store drain got pending, want empty"); end
  endtask

  task automatic test_single_row();
    int acc; bit ok;
    for (int w = 0; w < ROWW / 32; w++) rf_model[30][0][w*32 +: 32] = $urandom;
    send(2'b00, 5'd17, 2'd0, 15'd9, 14'd1, 14'd100, 1'b0, acc);
    send(2'b01, 5'd30, 2'd0, 15'h7FFF, 14'd5, 14'd1, 1'b0, acc);
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_row drain got pending, want empty"); end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2; bit ok;
    send(2'b00, 5'd1, 2'd3, 15'd40, 14'd1, 14'd4, 1'b1, acc1);
    send(2'b00, 5'd2, 2'd3, 15'd1000, 14'd1, 14'd20, 1'b0, acc2);
    checks++;
    if (acc2 != acc1 + 9) begin
      errors++;
      $display("FAIL b2b_accept got %0d cycles apart, want 9", acc2 - acc1);
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b drain got pending, want empty"); end
  endtask

  task automatic test_reset_mid();
    int acc; bit ok;
    send(2'b00, 5'd4, 2'd3, 15'd500, 14'd1, 14'd2, 1'b0, acc);
    while (cyc < acc + 3) @(negedge clk);
    rst = 1'b1;
    while (iss_q.size() > 0 && iss_q[$].cyc > acc + 3) void'(iss_q.pop_back());
    rfw_q.delete();
    done_q.delete();
    @(negedge clk);
    checks++;
    if ({bus.cmd_ready, bus.mem_we, bus.rf_we, bus.done_valid} !== 4'b1000 || bus.mem_addr !== 15'd0) begin
      errors++;
      $display("FAIL rst_mid ready/mem_we/rf_we/done %b addr %h, want 1000 0",
               {bus.cmd_ready, bus.mem_we, bus.rf_we, bus.done_valid}, bus.mem_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_ready got %b, want 1", bus.cmd_ready);
    end
    repeat (8) @(negedge clk);
    send(2'b11, 5'd11, 2'd0, 15'd0, 14'd0, 14'd0, 1'b0, acc);
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_mid drain got pending, want empty"); end
  endtask

  task automatic test_zero_nop();
    int acc; bit ok;
    logic [14:0] held;
    held = bus.mem_addr;
    send(2'b10, 5'd7, 2'd1, 15'd1234, 14'd9, 14'd9, 1'b0, acc);
    send(2'b11, 5'd9, 2'd2, 15'd4321, 14'd9, 14'd9, 1'b0, acc);
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL zero_nop drain got pending, want empty"); end
    checks++;
    if (bus.mem_addr !== held) begin
      errors++;
      $display("FAIL zero_addr_hold got %h, want %h", bus.mem_addr, held);
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_LAT; i++) hist[i] = '0;
    for (int g = 0; g < 32; g++)
      for (int r = 0; r < 4; r++) rf_model[g][r] = '0;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_reg = '0; bus.cmd_rows_m1 = '0;
    bus.cmd_addr = '0; bus.cmd_stride_x = '0; bus.cmd_stride_y = '0;
    test_reset();
    test_load_basic();
    test_load_wrap();
    test_store();
    test_single_row();
    test_back_to_back();
    test_reset_mid();
    test_zero_nop();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
